lane_deserializer: RTL and testbench

// Receive-side counterpart of the lane clock divider. It runs on the fast bit clock and rebuilds bytes

---
 rtl/lane_deserializer_if.sv | 32 +++
 rtl/lane_deserializer.sv | 137 +++++++++++++
 tb/tb_lane_deserializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lane_deserializer_if.sv
// Lane-side and byte-side signal bundle for lane_deserializer.
// The master is the lane sampler that drives beats and consumes bytes;
// the slave is the deserializer itself.
interface lane_deserializer_if;
    logic       single_lane;
    logic       lane_valid;
    logic [3:0] lane_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_seen;
    logic       locked;

    modport master (
        output single_lane,
        output lane_valid,
        output lane_data,
        input  byte_out,
        input  byte_valid,
        input  sync_seen,
        input  locked
    );

    modport slave (
        input  single_lane,
        input  lane_valid,
        input  lane_data,
        output byte_out,
        output byte_valid,
        output sync_seen,
        output locked
    );
endinterface

// File: rtl/lane_deserializer.sv
// Rebuilds bytes from a 1-lane x 8-beat or 4-lane x 2-beat serial stream,
// MSB first. Byte alignment is found by hunting for SYNC_BYTE at every bit
// (single lane) or nibble (four lanes) offset. Once locked, one byte is
// evaluated every beats-per-byte valid beats: sync bytes pulse sync_seen,
// every other byte is presented on byte_out with a one-cycle byte_valid.
// A gap in lane_valid or a change of lane mode drops the lock.
module lane_deserializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hBC
) (
    input  logic                clk_in,
    input  logic                rst_n,
    lane_deserializer_if.slave  lane_if
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e     state_q,      state_d;
    logic [7:0] shreg_q,      shreg_d;
    logic [2:0] cnt_q,        cnt_d;
    logic       mode_q,       mode_d;
    logic [7:0] byte_out_q,   byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       sync_seen_q,  sync_seen_d;
    logic       locked_q,     locked_d;

    logic [7:0] shreg_next;
    logic [2:0] last_beat;
    logic       lock_lost;

    // Shift-register value after absorbing this cycle's beat, in the current lane mode.
    always_comb begin
        if (lane_if.single_lane) begin
            shreg_next = {shreg_q[6:0], lane_if.lane_data[0]};
        end else begin
            shreg_next = {shreg_q[3:0], lane_if.lane_data};
        end
    end

    // Terminal beat count for the mode captured at lock entry, and the lock-loss condition.
    always_comb begin
        last_beat = mode_q ? 3'd7 : 3'd1;
        lock_lost = !lane_if.lane_valid || (lane_if.single_lane != mode_q);
    end

    // Next-state logic: alignment hunt, byte assembly and lock supervision.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        sync_seen_d  = 1'b0;
        locked_d     = locked_q;

        unique case (state_q)
            HUNT: begin
                if (lane_if.lane_valid) begin
                    shreg_d = shreg_next;
                    if (shreg_next == SYNC_BYTE) begin
                        // Alignment found: this sync byte is consumed silently.
                        state_d  = LOCKED;
                        cnt_d    = 3'd0;
                        mode_d   = lane_if.single_lane;
                        locked_d = 1'b1;
                    end
                end
            end

            LOCKED: begin
                if (lock_lost) begin
                    // Any partial byte is discarded along with the alignment.
                    state_d  = HUNT;
                    shreg_d  = 8'h00;
                    cnt_d    = 3'd0;
                    locked_d = 1'b0;
                end else begin
                    shreg_d = shreg_next;
                    if (cnt_q == last_beat) begin
                        cnt_d = 3'd0;
                        if (shreg_next == SYNC_BYTE) begin
                            sync_seen_d = 1'b1;
                        end else begin
                            byte_out_d   = shreg_next;
                            byte_valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and registered outputs.
    // NOTE: the shift register is reset along with the control state; a stale
    // partial pattern left over from before reset could otherwise complete a
    // false SYNC_BYTE match.
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shreg_q      <= 8'h00;
            cnt_q        <= 3'd0;
            mode_q       <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            sync_seen_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            sync_seen_q  <= sync_seen_d;
            locked_q     <= locked_d;
        end
    end

    assign lane_if.byte_out   = byte_out_q;
    assign lane_if.byte_valid = byte_valid_q;
    assign lane_if.sync_seen  = sync_seen_q;
    assign lane_if.locked     = locked_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed bench for lane_deserializer. Expected data bytes are queued when
// their beats are driven and popped by a monitor whenever byte_valid strobes;
// any strobe with an empty queue is an error.
module tb_lane_deserializer;

    logic clk_in;
    logic rst_n;

    lane_deserializer_if dut_if ();

    lane_deserializer #(
        .SYNC_BYTE(8'hBC)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .lane_if(dut_if)
    );

    int         total;
    int         bad;
    int         sync_cnt;
    logic [7:0] exp_q[$];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One beat: drive inputs after a falling edge, let the rising edge sample
    // them, and return at the next falling edge where outputs are stable.
    task automatic beat(input logic valid, input logic [3:0] data);
        dut_if.lane_valid = valid;
        dut_if.lane_data  = data;
        @(negedge clk_in);
    endtask

    // Send the low n bits of b on lane 0, MSB first.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            beat(1'b1, {3'b000, b[i]});
        end
    endtask

    // Send one byte as two nibbles, high nibble first.
    task automatic send_quad(input logic [7:0] b);
        beat(1'b1, b[7:4]);
        beat(1'b1, b[3:0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            beat(1'b0, 4'h0);
        end
    endtask

    // Scoreboard monitor: every byte strobe must match the oldest queued byte.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (dut_if.byte_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte_valid", 32'(dut_if.byte_valid), 32'd0);
                end else begin
                    check("byte_out", 32'(dut_if.byte_out), 32'(exp_q.pop_front()));
                end
            end
            if (dut_if.sync_seen) begin
                sync_cnt++;
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        sync_cnt = 0;
        rst_n    = 1'b0;
        dut_if.single_lane = 1'b1;
        dut_if.lane_valid  = 1'b0;
        dut_if.lane_data   = 4'h0;

        // Reset state.
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_locked",     32'(dut_if.locked),     32'd0);
        check("rst_byte_valid", 32'(dut_if.byte_valid), 32'd0);
        check("rst_sync_seen",  32'(dut_if.sync_seen),  32'd0);
        check("rst_byte_out",   32'(dut_if.byte_out),   32'd0);
        rst_n = 1'b1;
        idle(2);
        check("idle_locked", 32'(dut_if.locked), 32'd0);

        // Single lane: 0xBC then 0x5A.
        send_bits(8'h5E, 7);
        check("t1_locked_bit7", 32'(dut_if.locked), 32'd0);
        beat(1'b1, 4'h0);
        check("t1_locked_bit8", 32'(dut_if.locked), 32'd1);
        exp_q.push_back(8'h5A);
        send_bits(8'h2D, 7);
        check("t1_bv_beat7", 32'(dut_if.byte_valid), 32'd0);
        beat(1'b1, 4'h0);
        check("t1_bv_beat8", 32'(dut_if.byte_valid), 32'd1);
        check("t1_byte",     32'(dut_if.byte_out),   32'h5A);
        beat(1'b1, 4'h1);
        check("t1_bv_one_cycle", 32'(dut_if.byte_valid), 32'd0);
        check("t1_byte_hold",    32'(dut_if.byte_out),   32'h5A);

        // Gap drops the lock; switch to four lanes while hunting.
        idle(1);
        check("t1_gap_unlock", 32'(dut_if.locked), 32'd0);
        dut_if.single_lane = 1'b0;
        idle(2);

        // Four lanes: B,C,3,7,B,C,E,1.
        beat(1'b1, 4'hB);
        check("t2_locked_beat1", 32'(dut_if.locked), 32'd0);
        beat(1'b1, 4'hC);
        check("t2_locked_beat2", 32'(dut_if.locked), 32'd1);
        check("t2_no_sync_on_lock", 32'(dut_if.sync_seen), 32'd0);
        exp_q.push_back(8'h37);
        send_quad(8'h37);
        check("t2_byte_37", 32'(dut_if.byte_out), 32'h37);
        send_quad(8'hBC);
        check("t2_sync_seen", 32'(dut_if.sync_seen),  32'd1);
        check("t2_sync_no_bv", 32'(dut_if.byte_valid), 32'd0);
        exp_q.push_back(8'hE1);
        beat(1'b1, 4'hE);
        check("t2_sync_pulse_width", 32'(dut_if.sync_seen), 32'd0);
        beat(1'b1, 4'h1);
        check("t2_byte_E1", 32'(dut_if.byte_out), 32'hE1);
        // 0x0B followed by 0xC0 puts BC across a byte boundary: still data.
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'hC0);
        send_quad(8'h0B);
        send_quad(8'hC0);
        check("t2_straddle_locked", 32'(dut_if.locked), 32'd1);
        idle(1);
        check("t2_gap_unlock", 32'(dut_if.locked),   32'd0);
        check("t2_byte_hold",  32'(dut_if.byte_out), 32'hC0);

        // Single lane with junk 101 before 0xBC, then 0x81.
        dut_if.single_lane = 1'b1;
        idle(1);
        send_bits(8'h05, 3);
        send_bits(8'h5E, 7);
        check("t3_locked_early", 32'(dut_if.locked), 32'd0);
        beat(1'b1, 4'h0);
        check("t3_locked", 32'(dut_if.locked), 32'd1);
        exp_q.push_back(8'h81);
        send_bits(8'h81, 8);
        check("t3_byte_81", 32'(dut_if.byte_out), 32'h81);
        idle(1);

        // Four lanes: lane_valid dropped after beat 1 of a byte.
        dut_if.single_lane = 1'b0;
        idle(1);
        send_quad(8'hBC);
        check("t4_locked", 32'(dut_if.locked), 32'd1);
        beat(1'b1, 4'h4);
        beat(1'b0, 4'h0);
        check("t4_drop_unlock", 32'(dut_if.locked), 32'd0);
        beat(1'b1, 4'h5);
        check("t4_no_byte", 32'(dut_if.byte_valid), 32'd0);
        send_quad(8'hBC);
        check("t4_relock", 32'(dut_if.locked), 32'd1);
        exp_q.push_back(8'h9D);
        send_quad(8'h9D);
        check("t4_byte_9D", 32'(dut_if.byte_out), 32'h9D);
        idle(1);

        // Single lane: mode toggled mid-byte.
        dut_if.single_lane = 1'b1;
        idle(1);
        send_bits(8'hBC, 8);
        check("t5_locked", 32'(dut_if.locked), 32'd1);
        send_bits(8'h05, 3);
        dut_if.single_lane = 1'b0;
        beat(1'b1, 4'h1);
        check("t5_toggle_unlock", 32'(dut_if.locked),     32'd0);
        check("t5_toggle_no_bv",  32'(dut_if.byte_valid), 32'd0);
        idle(1);

        // Single lane: reset pulsed mid-byte.
        dut_if.single_lane = 1'b1;
        idle(1);
        send_bits(8'hBC, 8);
        check("t6_locked", 32'(dut_if.locked), 32'd1);
        send_bits(8'h0A, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_locked",   32'(dut_if.locked),   32'd0);
        check("t6_rst_byte_out", 32'(dut_if.byte_out), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        send_bits(8'h05, 4);
        send_bits(8'h5A, 8);
        check("t6_no_lock_after_rst", 32'(dut_if.locked), 32'd0);
        send_bits(8'hBC, 8);
        check("t6_relock", 32'(dut_if.locked), 32'd1);
        exp_q.push_back(8'h3C);
        send_bits(8'h3C, 8);
        check("t6_byte_3C", 32'(dut_if.byte_out), 32'h3C);
        idle(3);

        check("sync_count",     32'(sync_cnt),       32'd1);
        check("queue_drained",  32'(exp_q.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
